rob_complete_arbiter: RTL and testbench
=======================================

Name: rob_complete_arbiter

Overview:
Shares the ROB's CDB_W completion ports (complete_valid/complete_entry) among NUM_REQ functional-unit writeback requesters. Each cycle, a round-robin scan grants up to CDB_W waiting results. Granted results are registered and presented to the ROB and the physical-register wakeup logic on the next cycle. Sits between the FU writeback stage and the ROB in the R10K-style pipeline.

Parameters:
NUM_REQ, 8, number of FU writeback requesters (≥ CDB_W)
CDB_W, 3, completion slots per cycle (matches ROB superscalar width)
ROB_IDX_W, 5, ROB index width
PREG_W, 6, physical register tag width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i holds a finished result
req_rob_idx  in  NUM_REQ x ROB_IDX_W  ROB entry of requester i's instruction
req_preg  in  NUM_REQ x PREG_W  destination physical register of requester i
req_ready  out  NUM_REQ  combinational grant; result accepted this cycle
BPRecoverEN  in  1  branch-mispredict flush
complete_valid  out  CDB_W  registered per-slot valid to ROB
complete_entry  out  CDB_W x ROB_IDX_W  registered ROB index per slot
complete_preg  out  CDB_W x PREG_W  registered preg tag per slot

Behaviour:
- Handshake: a requester raises req_valid and holds valid and payload stable until it sees req_ready=1 in the same cycle. The transfer occurs on that clock edge.
- req_ready depends only on req_valid, rr_ptr, BPRecoverEN and reset. It must not depend on any ready signal, so there is no combinational loop.
- Scan order: rr_ptr, rr_ptr+1, … mod NUM_REQ. The first CDB_W valid requesters in that order are granted.
- Slot assignment: the k-th grant in scan order goes to slot k. Slots are filled contiguously from slot 0.
- Latency: 1 cycle. A grant at edge t appears on complete_* during cycle t+1.
- Unused slots: complete_valid=0, complete_entry=0, complete_preg=0.
- rr_ptr update: if there is at least one grant, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. With no grants, rr_ptr holds.
- All requesters valid: the pointer advances by CDB_W each cycle, so every requester waits at most ceil(NUM_REQ/CDB_W)-1 cycles.
- Flush (BPRecoverEN=1):
  - all req_ready=0 that cycle;
  - complete_* register cleared at the next edge;
  - rr_ptr unchanged.
  - Requesters drop squashed results themselves. The arbiter holds no other state.
- Reset (also mid-operation): at the edge with reset=1, complete_valid/entry/preg <= 0 and rr_ptr <= 0. req_ready=0 while reset=1.
- Reset has priority over flush. Flush has priority over grants.
- Fewer than CDB_W requests: all are granted in the same cycle.
- No requests: outputs go to 0 next cycle.

Optional Feature:
Macro ROB_CMPL_PERF_CNT_EN.
- Defined: adds output ports perf_grants (32 bits) and perf_denied (32 bits), both reset to 0.
  - perf_grants increments by the number of grants each non-flush cycle.
  - perf_denied increments by 1 each cycle in which at least one valid requester was not granted (includes flush cycles with any valid request).
  - Both wrap modulo 2^32.
- Undefined: the ports and counters do not exist. Arbitration behaviour is identical.

Test Plan:
1. reset=1 for 2 cycles, all req_valid=1 -> req_ready=0 throughout. After reset drops: complete_valid=000, and the first grants are requesters 0,1,2.
2. Only req 5 valid, rob_idx=17, preg=40 -> req_ready=8'b0010_0000 in the same cycle. Next cycle: complete_valid=001, complete_entry[0]=17, complete_preg[0]=40, rr_ptr=6.
3. All 8 held valid from reset -> grants {0,1,2}, {3,4,5}, {6,7,0} on successive cycles. Each appears in slots 0..2 one cycle later.
4. rr_ptr=6, req 1 and 6 valid -> slot0=req 6, slot1=req 1, complete_valid=011, rr_ptr=2.
5. req 0..3 valid with BPRecoverEN=1 -> req_ready=0, next-cycle complete_valid=000. On the following non-flush cycle, grants are 0,1,2 (pointer unchanged).
6. With ROB_CMPL_PERF_CNT_EN, run scenario 3 for 3 cycles -> perf_grants=9, perf_denied=3.

Source files
------------

// File: rtl/rob_complete_arbiter.sv
// Round-robin arbiter sharing the ROB completion ports among FU writebacks.
// Optional ROB_CMPL_PERF_CNT_EN adds grant/denial performance counters.
module rob_complete_arbiter #(
  parameter int unsigned NUM_REQ   = 8,
  parameter int unsigned CDB_W     = 3,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned PREG_W    = 6
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]   req_rob_idx,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]      req_preg,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                BPRecoverEN,
  output logic [CDB_W-1:0]                    complete_valid,
  output logic [CDB_W-1:0][ROB_IDX_W-1:0]     complete_entry,
  output logic [CDB_W-1:0][PREG_W-1:0]        complete_preg
`ifdef ROB_CMPL_PERF_CNT_EN
  ,
  output logic [31:0]                         perf_grants,
  output logic [31:0]                         perf_denied
`endif
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SLOT_W = $clog2(CDB_W + 1);

  logic [PTR_W-1:0]                r_rr_ptr;
  logic [CDB_W-1:0]                r_cv;
  logic [CDB_W-1:0][ROB_IDX_W-1:0] r_ce;
  logic [CDB_W-1:0][PREG_W-1:0]    r_cp;

  logic [NUM_REQ-1:0]              w_ready;
  logic [CDB_W-1:0]                w_sv;
  logic [CDB_W-1:0][ROB_IDX_W-1:0] w_se;
  logic [CDB_W-1:0][PREG_W-1:0]    w_sp;
  logic [SLOT_W-1:0]               w_cnt;
  logic [PTR_W-1:0]                w_idx;
  logic [PTR_W-1:0]                w_last;
  logic [PTR_W-1:0]                w_ptr_nxt;

  // Scan from the pointer; the k-th valid requester lands in slot k.
  always_comb begin
    w_ready = '0;
    w_sv    = '0;
    w_se    = '0;
    w_sp    = '0;
    w_cnt   = '0;
    w_idx   = '0;
    w_last  = r_rr_ptr;
    if (!reset && !BPRecoverEN) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        w_idx = PTR_W'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
        if (req_valid[w_idx] && (w_cnt < SLOT_W'(CDB_W))) begin
          w_ready[w_idx] = 1'b1;
          w_sv[w_cnt]    = 1'b1;
          w_se[w_cnt]    = req_rob_idx[w_idx];
          w_sp[w_cnt]    = req_preg[w_idx];
          w_cnt          = w_cnt + 1'b1;
          w_last         = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_ptr_nxt = r_rr_ptr;
    if (w_cnt != '0) begin
      w_ptr_nxt = PTR_W'((int'(w_last) + 1) % int'(NUM_REQ));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_cv     <= '0;
      r_ce     <= '0;
      r_cp     <= '0;
    end else if (BPRecoverEN) begin
      r_cv     <= '0;
      r_ce     <= '0;
      r_cp     <= '0;
    end else begin
      r_rr_ptr <= w_ptr_nxt;
      r_cv     <= w_sv;
      r_ce     <= w_se;
      r_cp     <= w_sp;
    end
  end

  assign req_ready      = w_ready;
  assign complete_valid = r_cv;
  assign complete_entry = r_ce;
  assign complete_preg  = r_cp;

`ifdef ROB_CMPL_PERF_CNT_EN
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_denied;
  logic        w_denied;

  // Flush cycles count as denials whenever anything was waiting.
  assign w_denied = |(req_valid & ~w_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_grants <= '0;
      r_perf_denied <= '0;
    end else begin
      r_perf_grants <= r_perf_grants + 32'(w_cnt);
      if (w_denied) begin
        r_perf_denied <= r_perf_denied + 32'd1;
      end
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_denied = r_perf_denied;
`endif

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Directed plus randomized checks of rob_complete_arbiter against a
// queue-based round-robin reference model.
module tb_rob_complete_arbiter;

  localparam int NUM_REQ   = 8;
  localparam int CDB_W     = 3;
  localparam int ROB_IDX_W = 5;
  localparam int PREG_W    = 6;

  logic                              clock;
  logic                              reset;
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ-1:0][PREG_W-1:0]    req_preg;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              BPRecoverEN;
  logic [CDB_W-1:0]                  complete_valid;
  logic [CDB_W-1:0][ROB_IDX_W-1:0]   complete_entry;
  logic [CDB_W-1:0][PREG_W-1:0]      complete_preg;
`ifdef ROB_CMPL_PERF_CNT_EN
  logic [31:0]                       perf_grants;
  logic [31:0]                       perf_denied;
  logic [31:0]                       m_pg;
  logic [31:0]                       m_pd;
`endif

  int checks = 0;
  int errors = 0;

  int                                m_ptr;
  logic [CDB_W-1:0]                  m_cv;
  logic [CDB_W-1:0][ROB_IDX_W-1:0]   m_ce;
  logic [CDB_W-1:0][PREG_W-1:0]      m_cp;
  logic [NUM_REQ-1:0]                g;

  rob_complete_arbiter #(
    .NUM_REQ(NUM_REQ), .CDB_W(CDB_W),
    .ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_rob_idx    (req_rob_idx),
    .req_preg       (req_preg),
    .req_ready      (req_ready),
    .BPRecoverEN    (BPRecoverEN),
    .complete_valid (complete_valid),
    .complete_entry (complete_entry),
    .complete_preg  (complete_preg)
`ifdef ROB_CMPL_PERF_CNT_EN
    ,
    .perf_grants    (perf_grants),
    .perf_denied    (perf_denied)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict grants, check req_ready, clock, check registers.
  task automatic cycle(output logic [NUM_REQ-1:0] gm);
    int q[$];
    logic [NUM_REQ-1:0] er;
    er = '0;
    if (!reset && !BPRecoverEN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_valid[(m_ptr + k) % NUM_REQ] && q.size() < CDB_W)
          q.push_back((m_ptr + k) % NUM_REQ);
      end
    end
    foreach (q[s]) er[q[s]] = 1'b1;
    #1;
    check("req_ready", 64'(req_ready), 64'(er));
    gm = er;
    @(posedge clock);
`ifdef ROB_CMPL_PERF_CNT_EN
    if (reset) begin
      m_pg = 0;
      m_pd = 0;
    end else begin
      m_pg = m_pg + 32'(q.size());
      if (|(req_valid & ~er)) m_pd = m_pd + 1;
    end
`endif
    m_cv = '0;
    m_ce = '0;
    m_cp = '0;
    if (reset) begin
      m_ptr = 0;
    end else if (!BPRecoverEN) begin
      foreach (q[s]) begin
        m_cv[s] = 1'b1;
        m_ce[s] = req_rob_idx[q[s]];
        m_cp[s] = req_preg[q[s]];
      end
      if (q.size() > 0) m_ptr = (q[$] + 1) % NUM_REQ;
    end
    #1;
    check("complete_valid", 64'(complete_valid), 64'(m_cv));
    check("complete_entry", 64'(complete_entry), 64'(m_ce));
    check("complete_preg", 64'(complete_preg), 64'(m_cp));
`ifdef ROB_CMPL_PERF_CNT_EN
    check("perf_grants", 64'(perf_grants), 64'(m_pg));
    check("perf_denied", 64'(perf_denied), 64'(m_pd));
`endif
  endtask

  initial begin
    m_ptr = 0;
    m_cv = '0;
    m_ce = '0;
    m_cp = '0;
`ifdef ROB_CMPL_PERF_CNT_EN
    m_pg = 0;
    m_pd = 0;
`endif
    reset = 1'b1;
    BPRecoverEN = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rob_idx[i] = ROB_IDX_W'(i + 8);
      req_preg[i]    = PREG_W'(i + 32);
    end

    cycle(g);
    check("rst_ready_held", 64'(req_ready), 64'(0));
    cycle(g);
    check("rst_cv_zero", 64'(complete_valid), 64'(0));
    check("rst_ready_zero", 64'(req_ready), 64'(0));

    reset = 1'b0;
    cycle(g);
    check("rr_cv_012", 64'(complete_valid), 64'h7);
    check("rr_ce_012", 64'(complete_entry), 64'({5'd10, 5'd9, 5'd8}));
    check("rr_next_345", 64'(req_ready), 64'h38);
    cycle(g);
    check("rr_ce_345", 64'(complete_entry), 64'({5'd13, 5'd12, 5'd11}));
    check("rr_next_670", 64'(req_ready), 64'hC1);
    cycle(g);
    check("rr_cp_670", 64'(complete_preg), 64'({6'd32, 6'd39, 6'd38}));
    check("rr_next_123", 64'(req_ready), 64'h0E);
`ifdef ROB_CMPL_PERF_CNT_EN
    check("perf_grants_9", 64'(perf_grants), 64'd9);
    check("perf_denied_3", 64'(perf_denied), 64'd3);
`endif

    req_valid = 8'h20;
    req_rob_idx[5] = 5'd17;
    req_preg[5] = 6'd40;
    #1;
    check("single_ready", 64'(req_ready), 64'h20);
    cycle(g);
    check("single_cv", 64'(complete_valid), 64'h1);
    check("single_ce", 64'(complete_entry[0]), 64'd17);
    check("single_cp", 64'(complete_preg[0]), 64'd40);

    req_valid = 8'h42;
    cycle(g);
    check("wrap_cv", 64'(complete_valid), 64'h3);
    check("wrap_ce0", 64'(complete_entry[0]), 64'd14);
    check("wrap_ce1", 64'(complete_entry[1]), 64'd9);

    reset = 1'b1;
    req_valid = '0;
    cycle(g);
    reset = 1'b0;
    req_valid = 8'h0F;
    BPRecoverEN = 1'b1;
    cycle(g);
    check("flush_cv", 64'(complete_valid), 64'h0);
    BPRecoverEN = 1'b0;
    cycle(g);
    check("post_flush_cv", 64'(complete_valid), 64'h7);
    check("post_flush_ce", 64'(complete_entry), 64'({5'd10, 5'd9, 5'd8}));

    for (int n = 0; n < 400; n++) begin
      req_valid = req_valid & ~g;
      if (reset || BPRecoverEN) req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && ($urandom_range(1, 0) == 1)) begin
          req_valid[i]   = 1'b1;
          req_rob_idx[i] = ROB_IDX_W'($urandom);
          req_preg[i]    = PREG_W'($urandom);
        end
      end
      BPRecoverEN = ($urandom_range(7, 0) == 0);
      reset       = ($urandom_range(39, 0) == 0);
      cycle(g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
